// File: rtl/mac_sequencer_if.sv
// Pipeline-side signal bundle for the MAC sequencer: Execute/Memory/Writeback
// control inputs and the sequencer's control and status outputs.
interface mac_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             MacValidE;
  logic [1:0]       MacOpE;
  logic             StallM;
  logic             FlushM;
  logic             StallW;
  logic             FlushW;
  logic             MulStart;
  logic             MacBusyE;
  logic             AccEn;
  logic             AccClr;
  logic             MacResSelE;
  logic             MacWbM;
  logic             MacWbW;
  logic [CNT_W-1:0] MacCount;

  modport slave (
    input  MacValidE, MacOpE, StallM, FlushM, StallW, FlushW,
    output MulStart, MacBusyE, AccEn, AccClr, MacResSelE, MacWbM, MacWbW, MacCount
  );

  modport master (
    output MacValidE, MacOpE, StallM, FlushM, StallW, FlushW,
    input  MulStart, MacBusyE, AccEn, AccClr, MacResSelE, MacWbM, MacWbW, MacCount
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequencer for the multi-cycle MAC unit in Execute: launches the multiplier,
// stalls Execute until the product is ready, and commits accumulator updates.
module mac_sequencer #(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  mac_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } stateT;

  localparam logic [1:0] OpClr = 2'b00;
  localparam logic [1:0] OpRd  = 2'b01;
  // Counter preload: the launch cycle and the final MUL cycle are both part of the busy span.
  localparam logic [3:0] CntInit = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  stateT            stateReg;
  stateT            stateNext;
  logic [3:0]       cntReg;
  logic [3:0]       cntNext;
  logic             macWbMReg;
  logic             macWbWReg;
  logic [CNT_W-1:0] macCountReg;

  logic adv;
  logic needMul;
  logic writesRd;
  logic mulStart;
  logic macBusy;
  logic accEn;
  logic accClr;
  logic resSel;

  assign adv      = ~bus.StallM & ~bus.FlushM;
  assign needMul  = bus.MacValidE & bus.MacOpE[1];
  assign writesRd = bus.MacValidE & bus.MacOpE[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    mulStart  = 1'b0;
    macBusy   = 1'b0;
    accEn     = 1'b0;
    accClr    = 1'b0;
    resSel    = 1'b0;
    if (!reset) begin
      case (stateReg)
        IDLE: begin
          if (needMul && !bus.FlushM) begin
            mulStart = 1'b1;
            macBusy  = 1'b1;
            if (MUL_LAT == 1) begin
              stateNext = DONE;
            end else begin
              stateNext = MUL;
              cntNext   = CntInit;
            end
          end else if (bus.MacValidE && bus.MacOpE == OpClr && adv) begin
            accClr = 1'b1;
          end
        end
        MUL: begin
          macBusy = 1'b1;
          if (bus.FlushM) begin
            stateNext = IDLE;
          end else if (cntReg == 4'd0) begin
            stateNext = DONE;
          end else begin
            cntNext = cntReg - 4'd1;
          end
        end
        DONE: begin
          // Holding in DONE under StallM keeps the op from relaunching the multiplier.
          resSel = writesRd;
          if (adv) begin
            accEn     = 1'b1;
            stateNext = IDLE;
          end else if (bus.FlushM) begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      macWbMReg   <= 1'b0;
      macWbWReg   <= 1'b0;
      macCountReg <= '0;
    end else begin
      // Only a finished multiply or a plain RD carries a writeback into Memory.
      if (adv) begin
        macWbMReg <= writesRd & ((stateReg == DONE) | (bus.MacOpE == OpRd));
      end else if (bus.FlushM) begin
        macWbMReg <= 1'b0;
      end
      if (bus.FlushW) begin
        macWbWReg <= 1'b0;
      end else if (!bus.StallW) begin
        macWbWReg <= macWbMReg;
      end
      if (accEn) begin
        macCountReg <= macCountReg + 1'b1;
      end
    end
  end

  assign bus.MulStart   = mulStart;
  assign bus.MacBusyE   = macBusy;
  assign bus.AccEn      = accEn;
  assign bus.AccClr     = accClr;
  assign bus.MacResSelE = resSel;
  assign bus.MacWbM     = macWbMReg;
  assign bus.MacWbW     = macWbWReg;
  assign bus.MacCount   = macCountReg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: each cycle's hand-computed outputs are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_mac_sequencer;

  localparam logic [1:0] OP_CLR   = 2'b00;
  localparam logic [1:0] OP_RD    = 2'b01;
  localparam logic [1:0] OP_ACC   = 2'b10;
  localparam logic [1:0] OP_ACCRD = 2'b11;

  // Flag order: {MulStart, MacBusyE, AccEn, AccClr, MacResSelE, MacWbM, MacWbW}
  localparam logic [6:0] F0   = 7'b0000000;
  localparam logic [6:0] FMS  = 7'b1000000;
  localparam logic [6:0] FB   = 7'b0100000;
  localparam logic [6:0] FEN  = 7'b0010000;
  localparam logic [6:0] FCLR = 7'b0001000;
  localparam logic [6:0] FSEL = 7'b0000100;
  localparam logic [6:0] FWBM = 7'b0000010;
  localparam logic [6:0] FWBW = 7'b0000001;

  typedef struct {
    string       tag;
    logic [6:0]  flags;
    logic [31:0] cnt;
  } expT;

  logic       clk;
  logic       reset;
  logic       macValidE;
  logic [1:0] macOpE;
  logic       stallM;
  logic       flushM;
  logic       stallW;
  logic       flushW;

  int compared   = 0;
  int mismatched = 0;
  expT sbQ[$];

  mac_sequencer_if #(.CNT_W(32)) busA ();
  mac_sequencer_if #(.CNT_W(4))  busB ();

  assign busA.MacValidE = macValidE;
  assign busA.MacOpE    = macOpE;
  assign busA.StallM    = stallM;
  assign busA.FlushM    = flushM;
  assign busA.StallW    = stallW;
  assign busA.FlushW    = flushW;
  assign busB.MacValidE = macValidE;
  assign busB.MacOpE    = macOpE;
  assign busB.StallM    = stallM;
  assign busB.FlushM    = flushM;
  assign busB.StallW    = stallW;
  assign busB.FlushW    = flushW;

  mac_sequencer #(.MUL_LAT(3), .CNT_W(32)) dutA (.clk(clk), .reset(reset), .bus(busA));
  mac_sequencer #(.MUL_LAT(3), .CNT_W(4))  dutB (.clk(clk), .reset(reset), .bus(busB));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: pops one expected record per checked cycle and compares both DUTs.
  expT        rec;
  logic [6:0] actA;
  logic [6:0] actB;
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      rec  = sbQ.pop_front();
      actA = {busA.MulStart, busA.MacBusyE, busA.AccEn, busA.AccClr,
              busA.MacResSelE, busA.MacWbM, busA.MacWbW};
      actB = {busB.MulStart, busB.MacBusyE, busB.AccEn, busB.AccClr,
              busB.MacResSelE, busB.MacWbM, busB.MacWbW};
      compared++;
      if ({actA, busA.MacCount} !== {rec.flags, rec.cnt}) begin
        mismatched++;
        $display("FAIL %s dutA: flags=%b count=%0d, required flags=%b count=%0d",
                 rec.tag, actA, busA.MacCount, rec.flags, rec.cnt);
      end
      compared++;
      if ({actB, busB.MacCount} !== {rec.flags, rec.cnt[3:0]}) begin
        mismatched++;
        $display("FAIL %s dutB: flags=%b count=%0d, required flags=%b count=%0d",
                 rec.tag, actB, busB.MacCount, rec.flags, rec.cnt[3:0]);
      end
      $display("chk %-12s flags=%b countA=%0d countB=%0d", rec.tag, actA,
               busA.MacCount, busB.MacCount);
    end
  end

  task automatic cyc(input string tag, input logic v, input logic [1:0] op,
                     input logic sM, input logic fM, input logic sW, input logic fW,
                     input logic rst, input logic [6:0] flags, input int unsigned cnt);
    expT e;
    @(posedge clk);
    #1;
    macValidE = v;
    macOpE    = op;
    stallM    = sM;
    flushM    = fM;
    stallW    = sW;
    flushW    = fW;
    reset     = rst;
    e.tag     = tag;
    e.flags   = flags;
    e.cnt     = cnt;
    sbQ.push_back(e);
  endtask

  initial begin
    reset     = 1'b1;
    macValidE = 1'b0;
    macOpE    = OP_CLR;
    stallM    = 1'b0;
    flushM    = 1'b0;
    stallW    = 1'b0;
    flushW    = 1'b0;

    // Reset: outputs gated even with an ACC presented
    cyc("rst0", 1, OP_ACC, 0, 0, 0, 0, 1, F0, 0);
    cyc("rst1", 0, OP_CLR, 0, 0, 0, 0, 1, F0, 0);

    // Single ACC
    cyc("acc_c0", 1, OP_ACC, 0, 0, 0, 0, 0, FMS | FB, 0);
    cyc("acc_c1", 1, OP_ACC, 0, 0, 0, 0, 0, FB, 0);
    cyc("acc_c2", 1, OP_ACC, 0, 0, 0, 0, 0, FB, 0);
    cyc("acc_c3", 1, OP_ACC, 0, 0, 0, 0, 0, FEN, 0);
    cyc("acc_c4", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 1);

    // ACCRD then RD back-to-back, FlushW squashes the RD in Memory
    cyc("accrd_c0", 1, OP_ACCRD, 0, 0, 0, 0, 0, FMS | FB, 1);
    cyc("accrd_c1", 1, OP_ACCRD, 0, 0, 0, 0, 0, FB, 1);
    cyc("accrd_c2", 1, OP_ACCRD, 0, 0, 0, 0, 0, FB, 1);
    cyc("accrd_c3", 1, OP_ACCRD, 0, 0, 0, 0, 0, FEN | FSEL, 1);
    cyc("rd_c4", 1, OP_RD, 0, 0, 0, 0, 0, FWBM, 2);
    cyc("rd_c5", 0, OP_CLR, 0, 0, 0, 1, 0, FWBM | FWBW, 2);
    cyc("rd_c6", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 2);

    // ACCRD held in DONE by StallM, then StallM/StallW hold the writeback bits
    cyc("stl_c0", 1, OP_ACCRD, 0, 0, 0, 0, 0, FMS | FB, 2);
    cyc("stl_c1", 1, OP_ACCRD, 0, 0, 0, 0, 0, FB, 2);
    cyc("stl_c2", 1, OP_ACCRD, 0, 0, 0, 0, 0, FB, 2);
    cyc("stl_c3", 1, OP_ACCRD, 1, 0, 0, 0, 0, FSEL, 2);
    cyc("stl_c4", 1, OP_ACCRD, 1, 0, 0, 0, 0, FSEL, 2);
    cyc("stl_c5", 1, OP_ACCRD, 1, 0, 0, 0, 0, FSEL, 2);
    cyc("stl_c6", 1, OP_ACCRD, 0, 0, 0, 0, 0, FEN | FSEL, 2);
    cyc("stl_c7", 0, OP_CLR, 1, 0, 0, 0, 0, FWBM, 3);
    cyc("stl_c8", 0, OP_CLR, 0, 0, 1, 0, 0, FWBM | FWBW, 3);
    cyc("stl_c9", 0, OP_CLR, 0, 0, 0, 0, 0, FWBW, 3);
    cyc("stl_c10", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 3);

    // FlushM during MUL
    cyc("fmul_c0", 1, OP_ACC, 0, 0, 0, 0, 0, FMS | FB, 3);
    cyc("fmul_c1", 1, OP_ACC, 0, 1, 0, 0, 0, FB, 3);
    cyc("fmul_c2", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 3);
    cyc("fmul_c3", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 3);

    // FlushM in DONE
    cyc("fdone_c0", 1, OP_ACCRD, 0, 0, 0, 0, 0, FMS | FB, 3);
    cyc("fdone_c1", 1, OP_ACCRD, 0, 0, 0, 0, 0, FB, 3);
    cyc("fdone_c2", 1, OP_ACCRD, 0, 0, 0, 0, 0, FB, 3);
    cyc("fdone_c3", 1, OP_ACCRD, 0, 1, 0, 0, 0, FSEL, 3);
    cyc("fdone_c4", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 3);
    cyc("fdone_c5", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 3);

    // CLR stalled then advanced; CLR stalled then flushed
    cyc("clr_c0", 1, OP_CLR, 1, 0, 0, 0, 0, F0, 3);
    cyc("clr_c1", 1, OP_CLR, 1, 0, 0, 0, 0, F0, 3);
    cyc("clr_c2", 1, OP_CLR, 0, 0, 0, 0, 0, FCLR, 3);
    cyc("clr_c3", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 3);
    cyc("clrf_c0", 1, OP_CLR, 1, 0, 0, 0, 0, F0, 3);
    cyc("clrf_c1", 1, OP_CLR, 0, 1, 0, 0, 0, F0, 3);
    cyc("clrf_c2", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 3);

    // RD flushed; RD stalled then advanced
    cyc("rdf_c0", 1, OP_RD, 0, 1, 0, 0, 0, F0, 3);
    cyc("rdf_c1", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 3);
    cyc("rds_c0", 1, OP_RD, 1, 0, 0, 0, 0, F0, 3);
    cyc("rds_c1", 1, OP_RD, 0, 0, 0, 0, 0, F0, 3);
    cyc("rds_c2", 0, OP_CLR, 0, 0, 0, 0, 0, FWBM, 3);
    cyc("rds_c3", 0, OP_CLR, 0, 0, 0, 0, 0, FWBW, 3);

    // Reset in the middle of a multiply
    cyc("rmid_c0", 1, OP_ACC, 0, 0, 0, 0, 0, FMS | FB, 3);
    cyc("rmid_c1", 1, OP_ACC, 0, 0, 0, 0, 0, FB, 3);
    cyc("rmid_c2", 1, OP_ACC, 0, 0, 0, 0, 1, F0, 3);
    cyc("rmid_c3", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 0);

    // Sixteen back-to-back ACCs: the 4-bit counter wraps to 0
    for (int i = 0; i < 16; i++) begin
      cyc($sformatf("wrap%0d_c0", i), 1, OP_ACC, 0, 0, 0, 0, 0, FMS | FB, i);
      cyc($sformatf("wrap%0d_c1", i), 1, OP_ACC, 0, 0, 0, 0, 0, FB, i);
      cyc($sformatf("wrap%0d_c2", i), 1, OP_ACC, 0, 0, 0, 0, 0, FB, i);
      cyc($sformatf("wrap%0d_c3", i), 1, OP_ACC, 0, 0, 0, 0, 0, FEN, i);
    end
    cyc("wrap_end", 0, OP_CLR, 0, 0, 0, 0, 0, F0, 16);

    for (int k = 0; k < 10 && sbQ.size() > 0; k++) @(negedge clk);
    #1;
    if (sbQ.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d records left, required 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Control sequencer for the custom multiply-accumulate resource in the integer Execute stage.
- Runs the multi-cycle multiply via a start pulse and an internal latency counter, and stalls Execute while the product is not ready.
- Commits accumulator clear/update only when the instruction leaves Execute unsquashed.
- Tracks the MAC register-writeback valid bit through Memory and Writeback, and counts committed accumulate operations.

Parameters:
- MUL_LAT, 3, multiplier latency in cycles from MulStart to product valid; legal range 1..15.
- CNT_W, 32, width of the committed-accumulate counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- MacValidE  in  1  MAC instruction present in Execute
- MacOpE  in  2  00 CLR (acc=0), 01 RD (rd=acc), 10 ACC (acc+=a*b), 11 ACCRD (acc+=a*b, rd=new acc)
- StallM  in  1  Execute->Memory advance blocked
- FlushM  in  1  instruction in Execute squashed (bubble into Memory)
- StallW  in  1  Memory->Writeback advance blocked
- FlushW  in  1  instruction in Memory squashed
- MulStart  out  1  one-cycle pulse launching the multiplier on current SrcA/SrcB
- MacBusyE  out  1  to hazard unit; stall Execute and earlier stages, insert bubble into Memory
- AccEn  out  1  one-cycle accumulator load (acc <= acc + product)
- AccClr  out  1  one-cycle accumulator clear
- MacResSelE  out  1  Execute result select: 1 = acc+product (ACCRD), 0 = current acc
- MacWbM  out  1  MAC result in Memory writes rd
- MacWbW  out  1  MAC result in Writeback writes rd
- MacCount  out  CNT_W  number of committed ACC/ACCRD operations

Behaviour:
- Advance condition: Adv = ~StallM & ~FlushM. Kill condition: FlushM.
- Op classes: NeedMul = MacValidE & MacOpE[1]. WritesRd = MacValidE & MacOpE[0].
- FSM states: IDLE, MUL, DONE. Internal counter cnt is 4 bits.
- IDLE, when NeedMul & ~FlushM:
  - MulStart=1 and MacBusyE=1 in the same cycle.
  - If MUL_LAT==1, next state is DONE.
  - Otherwise next state is MUL with cnt=MUL_LAT-2.
- MUL:
  - MacBusyE=1.
  - If FlushM, go to IDLE.
  - Else if cnt==0, go to DONE.
  - Else cnt decrements by 1.
- Busy span: MacBusyE is high for exactly MUL_LAT consecutive cycles per multiply op absent flush.
- DONE:
  - MacBusyE=0. MacResSelE=MacOpE[0].
  - On Adv: AccEn=1, then go to IDLE.
  - On FlushM: go to IDLE with no AccEn.
  - On StallM (no flush): stay in DONE with no pulse.
- CLR/RD in IDLE: no busy cycle.
  - CLR: AccClr=1 in the cycle Adv is high.
  - RD: MacResSelE=0.
  - Under StallM nothing is asserted until Adv. Under FlushM nothing is asserted.
- Output timing: MacBusyE, MulStart, AccEn, AccClr and MacResSelE are combinational from state and inputs. MacResSelE is 0 whenever MacValidE=0.
- Ordering: AccEn and AccClr are never both 1. An op in Execute never re-launches the multiplier after its own DONE, because the DONE->IDLE transition happens only on Adv or FlushM.
- MacWbM (register):
  - On Adv: MacWbM <= WritesRd, where WritesRd is qualified by the state being DONE or by the op being RD.
  - On FlushM: MacWbM <= 0.
  - On StallM: hold.
- MacWbW (register):
  - If FlushW: MacWbW <= 0.
  - Else if ~StallW: MacWbW <= MacWbM.
  - Else hold.
- MacCount: increments by 1 on each AccEn and wraps from 2^CNT_W-1 to 0. CLR does not affect it.
- Reset (sync, priority over all other inputs):
  - State=IDLE, cnt=0, MacWbM=0, MacWbW=0, MacCount=0.
  - All combinational outputs are 0 during reset.
  - Reset mid-MUL or mid-DONE aborts with no AccEn.
- Back-to-back: after DONE advances, the next MAC op in Execute is seen in IDLE on the following cycle and starts a fresh multiply.
- Precise traps: traps on MAC ops are supported only through FlushM while the op is still in Execute. Once the op has advanced, the accumulator side effect is not rolled back.

Test Plan:
- MUL_LAT=3, single ACC op, StallM=0: MulStart at cycle 0; MacBusyE high cycles 0-2; DONE at cycle 3 with AccEn=1 and MacResSelE=0; MacWbM=0 at cycle 4; MacCount=1.
- ACCRD followed by RD back-to-back: AccEn at cycle 3 with MacResSelE=1; MacWbM=1 at cycle 4 and MacWbW=1 at cycle 5; the RD starts at cycle 4 with no busy cycle and MacResSelE=0; MacWbM=1 at cycle 5; MacCount=1.
- ACC with StallM held high during cycles 3-5: state stays DONE and AccEn=0 for those cycles; AccEn=1 exactly once at cycle 6; MacCount=1.
- FlushM asserted at cycle 1 of an ACC op: return to IDLE at cycle 2; no AccEn ever; MacWbM=0; MacCount=0. Repeat with the flush at DONE; same result.
- CLR under StallM for 2 cycles, then Adv: AccClr=1 only in the Adv cycle; with FlushM instead of Adv, AccClr is never asserted.
- Reset asserted at cycle 2 of an ACC op: at cycle 3 the state is IDLE, all outputs are 0, and MacCount=0. With CNT_W=4, 16 committed ACCs wrap MacCount from 15 to 0.
